// File: rtl/trackball_quad_gen.sv
`timescale 1ns/1ps
// trackball_quad_gen
// Turns relative motion (mouse packets or joystick) into a clk/dir step stream per axis.
// Each axis keeps a signed saturating accumulator that is drained one count per step.
// A step is 1 clock of direction setup, HALF_PER clocks high and HALF_PER clocks low.
module trackball_quad_gen #(
  parameter int AXES     = 2,
  parameter int ACC_W    = 12,
  parameter int HALF_PER = 250,
  parameter int JOY_PER  = 4000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flip,
  input  logic [1:0]          speed,
  input  logic                joy_sens,
  input  logic [AXES-1:0]     delta_valid,
  input  logic [AXES*9-1:0]   delta,
  input  logic [AXES-1:0]     joy_pos,
  input  logic [AXES-1:0]     joy_neg,
  output logic [AXES-1:0]     q_clk,
  output logic [AXES-1:0]     q_dir,
  output logic [AXES-1:0]     acc_sat
);

  // The sum is kept wide enough that a doubled 9-bit delta on top of a full accumulator
  // cannot wrap before the clamp looks at it.
  localparam int SUM_W = ((ACC_W > 10) ? ACC_W : 10) + 3;
  localparam int HCW   = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
  localparam int JCW   = (JOY_PER > 1) ? $clog2(JOY_PER) : 1;
  localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((2 ** (ACC_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] ACC_MIN = -ACC_MAX;

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} step_state_t;

  logic [JCW-1:0]          joy_cnt;
  logic                    joy_wrap;
  logic signed [SUM_W-1:0] joy_mag;

  assign joy_wrap = (joy_cnt == JCW'(JOY_PER - 1));
  assign joy_mag  = joy_sens ? SUM_W'(2) : SUM_W'(1);

  // Free-running joystick rate counter shared by every axis.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      joy_cnt <= '0;
    end else if (joy_wrap) begin
      joy_cnt <= '0;
    end else begin
      joy_cnt <= joy_cnt + JCW'(1);
    end
  end

  for (genvar a = 0; a < AXES; a++) begin : g_axis
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [SUM_W-1:0] acc_ext;
    logic signed [SUM_W-1:0] delta_ext;
    logic signed [SUM_W-1:0] delta_scaled;
    logic signed [SUM_W-1:0] joy_inc;
    logic signed [SUM_W-1:0] take;
    logic signed [SUM_W-1:0] sum;
    logic [8:0]              delta_raw;
    logic                    clamp;
    logic                    leave_idle;
    step_state_t             state;
    logic [HCW-1:0]          half_cnt;
    logic                    clk_q;
    logic                    dir_q;
    logic                    sat_q;

    assign delta_raw  = delta[9*a +: 9];
    assign delta_ext  = {{(SUM_W-9){delta_raw[8]}}, delta_raw};
    assign acc_ext    = {{(SUM_W-ACC_W){acc[ACC_W-1]}}, acc};
    assign leave_idle = (state == IDLE) && (acc != '0);

    // Combine delta, joystick increment and the step being taken into one saturated update,
    // so events landing in the same cycle are all accounted for.
    always_comb begin
      delta_scaled = '0;
      joy_inc      = '0;
      take         = '0;
      clamp        = 1'b0;
      if (delta_valid[a]) begin
        case (speed)
          2'd0:    delta_scaled = delta_ext >>> 2;
          2'd1:    delta_scaled = delta_ext >>> 1;
          2'd2:    delta_scaled = delta_ext;
          default: delta_scaled = delta_ext <<< 1;
        endcase
      end
      if (joy_wrap && (joy_pos[a] ^ joy_neg[a])) begin
        joy_inc = joy_pos[a] ? joy_mag : -joy_mag;
      end
      if (leave_idle) begin
        take = acc[ACC_W-1] ? '1 : SUM_W'(1);
      end
      sum = acc_ext + delta_scaled + joy_inc - take;
      if (sum > ACC_MAX) begin
        acc_next = ACC_MAX[ACC_W-1:0];
        clamp    = 1'b1;
      end else if (sum < ACC_MIN) begin
        acc_next = ACC_MIN[ACC_W-1:0];
        clamp    = 1'b1;
      end else begin
        acc_next = sum[ACC_W-1:0];
      end
    end

    // Accumulator register and sticky saturation flag, released once the count is drained.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        acc   <= '0;
        sat_q <= 1'b0;
      end else begin
        acc <= acc_next;
        if (clamp) begin
          sat_q <= 1'b1;
        end else if (acc_next == '0) begin
          sat_q <= 1'b0;
        end
      end
    end

    // Step generator: latch direction, then one full high/low step clock per count.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state    <= IDLE;
        half_cnt <= '0;
        clk_q    <= 1'b0;
        dir_q    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (acc != '0) begin
              dir_q <= (~acc[ACC_W-1]) ^ flip;
              state <= SETUP;
            end
          end
          SETUP: begin
            clk_q    <= 1'b1;
            half_cnt <= '0;
            state    <= HIGH;
          end
          HIGH: begin
            if (half_cnt == HCW'(HALF_PER - 1)) begin
              clk_q    <= 1'b0;
              half_cnt <= '0;
              state    <= LOW;
            end else begin
              half_cnt <= half_cnt + HCW'(1);
            end
          end
          LOW: begin
            if (half_cnt == HCW'(HALF_PER - 1)) begin
              half_cnt <= '0;
              state    <= IDLE;
            end else begin
              half_cnt <= half_cnt + HCW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end

    assign q_clk[a]   = clk_q;
    assign q_dir[a]   = dir_q;
    assign acc_sat[a] = sat_q;
  end

endmodule

// File: tb/tb_trackball_quad_gen.sv
`timescale 1ns/1ps
// Bench for trackball_quad_gen: per-cycle comparison against an event-level model plus
// table-driven single-delta vectors and hand-written corner sequences.
module tb_trackball_quad_gen;

  localparam int AXES     = 2;
  localparam int ACC_W    = 8;
  localparam int HALF_PER = 4;
  localparam int JOY_PER  = 50;
  localparam int PERIOD   = 2 * HALF_PER + 2;
  localparam int LIM      = (1 << (ACC_W - 1)) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              flip;
  logic [1:0]        speed;
  logic              joy_sens;
  logic [AXES-1:0]   delta_valid;
  logic [AXES*9-1:0] delta;
  logic [AXES-1:0]   joy_pos;
  logic [AXES-1:0]   joy_neg;
  logic [AXES-1:0]   q_clk;
  logic [AXES-1:0]   q_dir;
  logic [AXES-1:0]   acc_sat;

  trackball_quad_gen #(
    .AXES(AXES), .ACC_W(ACC_W), .HALF_PER(HALF_PER), .JOY_PER(JOY_PER)
  ) dut (
    .clk(clk), .reset(reset), .flip(flip), .speed(speed), .joy_sens(joy_sens),
    .delta_valid(delta_valid), .delta(delta), .joy_pos(joy_pos), .joy_neg(joy_neg),
    .q_clk(q_clk), .q_dir(q_dir), .acc_sat(acc_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int axis;
    int spd;
    int d;
    bit flp;
    int exp_n;
    bit exp_dir;
  } vec_t;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  // model: accumulator value, time the axis is free to start a step, last step start, direction
  int m_acc[AXES];
  int m_free[AXES];
  int m_start[AXES];
  bit m_dir[AXES];
  bit m_sat[AXES];
  int m_jc;

  int              pulse_cnt[AXES];
  int              pos_cnt[AXES];
  int              first_rise[AXES];
  int              last_rise[AXES];
  int              min_gap[AXES];
  int              max_gap[AXES];
  logic [31:0]     dir_hist[AXES];
  logic [AXES-1:0] prev_clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic int floor_div(input int n, input int k);
    if (n >= 0) return n / k;
    return -((-n + k - 1) / k);
  endfunction

  function automatic int scale(input int d, input logic [1:0] s);
    case (s)
      2'd0:    return floor_div(d, 4);
      2'd1:    return floor_div(d, 2);
      2'd2:    return d;
      default: return 2 * d;
    endcase
  endfunction

  task automatic reset_model();
    for (int a = 0; a < AXES; a++) begin
      m_acc[a]   = 0;
      m_free[a]  = 0;
      m_start[a] = -1000;
      m_dir[a]   = 1'b0;
      m_sat[a]   = 1'b0;
    end
    m_jc     = 0;
    prev_clk = '0;
  endtask

  task automatic clear_stats();
    for (int a = 0; a < AXES; a++) begin
      pulse_cnt[a]  = 0;
      pos_cnt[a]    = 0;
      first_rise[a] = -1;
      last_rise[a]  = -1;
      min_gap[a]    = 1 << 30;
      max_gap[a]    = 0;
      dir_hist[a]   = '0;
    end
  endtask

  // One clock edge of the model: a step starts whenever the axis is free and owes counts.
  task automatic model_edge();
    bit wrap;
    int take;
    int inc;
    int d;
    int sum;
    cyc++;
    wrap = (m_jc == JOY_PER - 1);
    m_jc = wrap ? 0 : m_jc + 1;
    for (int a = 0; a < AXES; a++) begin
      take = 0;
      if (cyc >= m_free[a] && m_acc[a] != 0) begin
        take       = (m_acc[a] > 0) ? 1 : -1;
        m_dir[a]   = (m_acc[a] > 0) ^ flip;
        m_start[a] = cyc;
        m_free[a]  = cyc + PERIOD;
      end
      inc = 0;
      if (wrap && (joy_pos[a] != joy_neg[a])) inc = (joy_sens ? 2 : 1) * (joy_pos[a] ? 1 : -1);
      d   = delta_valid[a] ? scale($signed(delta[9*a +: 9]), speed) : 0;
      sum = m_acc[a] + d + inc - take;
      if (sum > LIM) begin
        sum = LIM;
        m_sat[a] = 1'b1;
      end else if (sum < -LIM) begin
        sum = -LIM;
        m_sat[a] = 1'b1;
      end else if (sum == 0) begin
        m_sat[a] = 1'b0;
      end
      m_acc[a] = sum;
    end
  endtask

  task automatic check_outputs();
    logic [AXES-1:0] ec, ed, es;
    for (int a = 0; a < AXES; a++) begin
      ec[a] = (cyc >= m_start[a] + 1) && (cyc <= m_start[a] + HALF_PER);
      ed[a] = m_dir[a];
      es[a] = m_sat[a];
    end
    check($sformatf("outputs@%0d", cyc), int'({q_clk, q_dir, acc_sat}), int'({ec, ed, es}));
    for (int a = 0; a < AXES; a++) begin
      if (q_clk[a] && !prev_clk[a]) begin
        pulse_cnt[a]++;
        if (q_dir[a]) pos_cnt[a]++;
        dir_hist[a] = {dir_hist[a][30:0], q_dir[a]};
        if (last_rise[a] >= 0) begin
          if (cyc - last_rise[a] < min_gap[a]) min_gap[a] = cyc - last_rise[a];
          if (cyc - last_rise[a] > max_gap[a]) max_gap[a] = cyc - last_rise[a];
        end else begin
          first_rise[a] = cyc;
        end
        last_rise[a] = cyc;
      end
    end
    prev_clk = q_clk;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  function automatic bit model_quiet();
    for (int a = 0; a < AXES; a++)
      if (m_acc[a] != 0 || cyc < m_free[a]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while (!model_quiet() && n < budget) begin
      tick();
      n++;
    end
    check("drain_budget", int'(n < budget), 1);
    tick();
    tick();
  endtask

  task automatic applyStimulus(input int axis, input int d);
    delta_valid             = '0;
    delta                   = '0;
    delta_valid[axis]       = 1'b1;
    delta[9*axis +: 9]      = 9'(d);
    tick();
    delta_valid             = '0;
  endtask

  task automatic checkOutput(input string name, input int axis, input int exp_n, input bit exp_dir);
    check({name, "_pulses"}, pulse_cnt[axis], exp_n);
    check({name, "_dir"}, pos_cnt[axis], exp_dir ? exp_n : 0);
    check({name, "_other_axis"}, pulse_cnt[1 - axis], 0);
  endtask

  vec_t vecs[10];

  initial begin
    int e;
    int n;
    vecs[0] = '{0, 2,  3, 1'b0, 3, 1'b1};
    vecs[1] = '{0, 0, -1, 1'b0, 1, 1'b0};
    vecs[2] = '{0, 0,  3, 1'b0, 0, 1'b1};
    vecs[3] = '{1, 1, -5, 1'b0, 3, 1'b0};
    vecs[4] = '{0, 3,  4, 1'b0, 8, 1'b1};
    vecs[5] = '{1, 2, -2, 1'b1, 2, 1'b1};
    vecs[6] = '{0, 0, -4, 1'b0, 1, 1'b0};
    vecs[7] = '{1, 3, -3, 1'b1, 6, 1'b1};
    vecs[8] = '{0, 1,  1, 1'b0, 0, 1'b1};
    vecs[9] = '{1, 0,  7, 1'b0, 1, 1'b1};

    reset       = 1'b1;
    flip        = 1'b0;
    speed       = 2'd2;
    joy_sens    = 1'b0;
    delta_valid = '0;
    delta       = '0;
    joy_pos     = '0;
    joy_neg     = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    reset_model();
    clear_stats();
    check("reset_q_clk", int'(q_clk), 0);
    check("reset_q_dir", int'(q_dir), 0);
    check("reset_acc_sat", int'(acc_sat), 0);
    repeat (5) tick();

    // single-delta vectors from idle
    for (int i = 0; i < 10; i++) begin
      speed = 2'(vecs[i].spd);
      flip  = vecs[i].flp;
      clear_stats();
      applyStimulus(vecs[i].axis, vecs[i].d);
      e = cyc;
      drain(2000);
      checkOutput($sformatf("vec%0d", i), vecs[i].axis, vecs[i].exp_n, vecs[i].exp_dir);
      if (vecs[i].exp_n > 0)
        check($sformatf("vec%0d_first_rise_latency", i), first_rise[vecs[i].axis] - e, 2);
      if (vecs[i].exp_n > 1) begin
        check($sformatf("vec%0d_min_period", i), min_gap[vecs[i].axis], PERIOD);
        check($sformatf("vec%0d_max_period", i), max_gap[vecs[i].axis], PERIOD);
      end
    end

    // reset asserted while axis 0 is in the high phase of a positive step
    speed = 2'd2;
    flip  = 1'b0;
    clear_stats();
    applyStimulus(0, 3);
    n = 0;
    while (!q_clk[0] && n < 20) begin
      tick();
      n++;
    end
    check("rst_reached_high", int'(q_clk[0]), 1);
    tick();
    check("rst_dir_before", int'(q_dir[0]), 1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_q_clk", int'(q_clk), 0);
    check("rst_async_q_dir", int'(q_dir), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    reset_model();
    clear_stats();
    repeat (3 * PERIOD) tick();
    check("rst_no_steps_after", pulse_cnt[0] + pulse_cnt[1], 0);

    // saturation: first step starts during the burst, then 127 counts remain after the clamp
    speed = 2'd3;
    clear_stats();
    delta_valid    = '0;
    delta          = '0;
    delta_valid[0] = 1'b1;
    delta[8:0]     = 9'd255;
    repeat (10) tick();
    delta_valid = '0;
    check("sat_flag_set", int'(acc_sat[0]), 1);
    drain(3000);
    checkOutput("sat", 0, 128, 1'b1);
    check("sat_flag_cleared", int'(acc_sat[0]), 0);

    // joystick: three wraps with sens=1 give +6
    speed    = 2'd2;
    joy_sens = 1'b1;
    clear_stats();
    joy_pos[1] = 1'b1;
    repeat (3 * JOY_PER) tick();
    joy_pos = '0;
    drain(2000);
    checkOutput("joy_pos", 1, 6, 1'b1);

    // joystick both directions held: nothing counted
    clear_stats();
    joy_pos[1] = 1'b1;
    joy_neg[1] = 1'b1;
    repeat (3 * JOY_PER) tick();
    joy_pos = '0;
    joy_neg = '0;
    drain(2000);
    check("joy_both_pulses", pulse_cnt[1], 0);

    // joystick negative with sens=0: two wraps give -2
    joy_sens = 1'b0;
    clear_stats();
    joy_neg[0] = 1'b1;
    repeat (2 * JOY_PER) tick();
    joy_neg = '0;
    drain(2000);
    checkOutput("joy_neg", 0, 2, 1'b0);

    // sign reversal mid-step with flip: +1 step finishes as dir 0, then two dir 1 steps
    flip = 1'b1;
    clear_stats();
    applyStimulus(0, 1);
    n = 0;
    while (!q_clk[0] && n < 20) begin
      tick();
      n++;
    end
    check("rev_reached_high", int'(q_clk[0]), 1);
    applyStimulus(0, -2);
    drain(2000);
    check("rev_pulses", pulse_cnt[0], 3);
    check("rev_dir_order", int'(dir_hist[0][2:0]), 3);

    // randomized traffic on both axes
    flip = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      for (int a = 0; a < AXES; a++) begin
        delta_valid[a]  = ($urandom_range(0, 15) == 0);
        delta[9*a +: 9] = 9'($urandom);
      end
      if (i % 97 == 0) begin
        speed    = 2'($urandom);
        joy_sens = 1'($urandom);
      end
      if (i % 41 == 0) begin
        joy_pos = AXES'($urandom);
        joy_neg = AXES'($urandom);
        flip    = 1'($urandom);
      end
      tick();
    end
    delta_valid = '0;
    joy_pos     = '0;
    joy_neg     = '0;
    drain(4000);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
